// File: rtl/ifetch_stage.sv
// ifetch_stage: instruction fetch stage between the PC stage and decode.
// Issues one aligned memory read per fetch_go, holds the returned word until
// decode accepts it, then pulses pc_en so the PC stage can advance.
// Optional feature: define IFETCH_TIMEOUT_EN to abort a request that is not
// acknowledged within TIMEOUT_CYCLES cycles (sticky timeout, FSM -> ERR).
module ifetch_stage #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] pc,
  input  logic        fetch_go,
  input  logic        flush,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_pc,
  output logic        pc_en,
  output logic        fetch_err,
  output logic        timeout
);

  typedef enum logic [1:0] {IDLE, REQ, VALID, ERR} state_t;

  state_t      state;
  state_t      state_next;
  logic        req_next;
  logic [31:0] addr_next;
  logic [31:0] instr_next;
  logic [31:0] ipc_next;
  logic        valid_next;
  logic        pc_en_next;
  logic        err_next;
  logic        drop;
  logic        drop_next;

`ifdef IFETCH_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] tcnt;
  logic [CW-1:0] tcnt_next;
  logic          timeout_next;
`endif

  // Next-state and next-output logic; every output is the registered copy
  // of a value computed here, so nothing combinational reaches a port.
  always_comb begin
    state_next = state;
    req_next   = imem_req;
    addr_next  = imem_addr;
    instr_next = instr;
    ipc_next   = instr_pc;
    valid_next = instr_valid;
    pc_en_next = 1'b0;
    err_next   = fetch_err;
    drop_next  = drop;
`ifdef IFETCH_TIMEOUT_EN
    tcnt_next    = tcnt;
    timeout_next = timeout;
`endif
    case (state)
      IDLE: begin
        req_next   = 1'b0;
        valid_next = 1'b0;
        if (fetch_go) begin
          if (pc[1:0] == 2'b00) begin
            state_next = REQ;
            req_next   = 1'b1;
            addr_next  = pc;
            ipc_next   = pc;
            drop_next  = 1'b0;
`ifdef IFETCH_TIMEOUT_EN
            tcnt_next  = '0;
`endif
          end else begin
            state_next = ERR;
            err_next   = 1'b1;
          end
        end
      end
      REQ: begin
        if (imem_ack) begin
          req_next  = 1'b0;
          drop_next = 1'b0;
          if (drop || flush) begin
            state_next = IDLE;
          end else begin
            instr_next = imem_rdata;
            valid_next = 1'b1;
            state_next = VALID;
          end
        end else begin
          if (flush) begin
            drop_next = 1'b1;
          end
`ifdef IFETCH_TIMEOUT_EN
          if (int'(tcnt) >= TIMEOUT_CYCLES - 1) begin
            timeout_next = 1'b1;
            req_next     = 1'b0;
            drop_next    = 1'b0;
            state_next   = ERR;
          end else begin
            tcnt_next = tcnt + CW'(1);
          end
`endif
        end
      end
      VALID: begin
        if (flush) begin
          valid_next = 1'b0;
          state_next = IDLE;
        end else if (instr_ready) begin
          valid_next = 1'b0;
          pc_en_next = 1'b1;
          state_next = IDLE;
        end
      end
      ERR: begin
        req_next   = 1'b0;
        valid_next = 1'b0;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State and output registers, cleared asynchronously while reset is low.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      imem_req    <= 1'b0;
      imem_addr   <= '0;
      instr       <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
      pc_en       <= 1'b0;
      fetch_err   <= 1'b0;
      drop        <= 1'b0;
    end else begin
      state       <= state_next;
      imem_req    <= req_next;
      imem_addr   <= addr_next;
      instr       <= instr_next;
      instr_pc    <= ipc_next;
      instr_valid <= valid_next;
      pc_en       <= pc_en_next;
      fetch_err   <= err_next;
      drop        <= drop_next;
    end
  end

`ifdef IFETCH_TIMEOUT_EN
  // Timeout counter and sticky timeout flag.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tcnt    <= '0;
      timeout <= 1'b0;
    end else begin
      tcnt    <= tcnt_next;
      timeout <= timeout_next;
    end
  end
`else
  // Feature disabled: the flag is a constant zero (a legal cycle count is
  // never negative), so no counter or flop exists.
  assign timeout = (TIMEOUT_CYCLES < 0);
`endif

endmodule

// File: tb/tb_ifetch_stage.sv
// tb_ifetch_stage: self-checking bench for ifetch_stage. Directed scenarios
// plus a randomized run scored against a transaction-level expectation.
// Honours IFETCH_TIMEOUT_EN for the timeout scenario (TIMEOUT_CYCLES=8).
module tb_ifetch_stage;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] pc = '0;
  logic        fetch_go = 1'b0;
  logic        flush = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr_pc;
  logic        pc_en;
  logic        fetch_err;
  logic        timeout;

  int checks = 0;
  int failures = 0;

  ifetch_stage #(.TIMEOUT_CYCLES(8)) dut (
    .clock(clock), .reset(reset), .pc(pc), .fetch_go(fetch_go), .flush(flush),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .instr_pc(instr_pc), .pc_en(pc_en),
    .fetch_err(fetch_err), .timeout(timeout)
  );

  // Free-running clock, 10 time units per period.
  always #5 clock = ~clock;

  // Advance one cycle and settle just after the rising edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Return all inputs to idle and pulse reset.
  task automatic do_reset();
    fetch_go = 1'b0; flush = 1'b0; imem_ack = 1'b0; instr_ready = 1'b0;
    reset = 1'b0;
    step();
    reset = 1'b1;
    step();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #1 reset = 1'b0;
    #1;
    checks++;
    if ({imem_req, instr_valid, pc_en, fetch_err, timeout} !== 5'b0) begin
      failures++;
      $display("[TB] FAIL reset_flags got=%b exp=00000", {imem_req, instr_valid, pc_en, fetch_err, timeout});
    end
    checks++;
    if ({imem_addr, instr, instr_pc} !== 96'h0) begin
      failures++;
      $display("[TB] FAIL reset_data got=%h exp=0", {imem_addr, instr, instr_pc});
    end
    step();
    reset = 1'b1;
    step();
  endtask

  task automatic test_basic_fetch();
    do_reset();
    pc = 32'h0000_0010; fetch_go = 1'b1; instr_ready = 1'b1;
    step(); fetch_go = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h10) begin
        failures++;
        $display("[TB] FAIL basic_req_c%0d got=%b/%h exp=1/00000010", c, imem_req, imem_addr);
      end
      if (c == 3) begin
        imem_ack = 1'b1; imem_rdata = 32'h0123_4567;
      end
      step();
    end
    imem_ack = 1'b0;
    checks++;
    if ({instr_valid, imem_req, pc_en} !== 3'b100 || instr !== 32'h0123_4567 || instr_pc !== 32'h10) begin
      failures++;
      $display("[TB] FAIL basic_valid got=%b %h %h exp=100 01234567 00000010", {instr_valid, imem_req, pc_en}, instr, instr_pc);
    end
    step();
    checks++;
    if (pc_en !== 1'b1 || instr_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL basic_pc_en got=%b/%b exp=1/0", pc_en, instr_valid);
    end
    step();
    checks++;
    if (pc_en !== 1'b0) begin
      failures++;
      $display("[TB] FAIL basic_pc_en_once got=%b exp=0", pc_en);
    end
    instr_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    int pulses;
    logic [31:0] word;
    do_reset();
    word = $urandom;
    pc = 32'h0000_0020; fetch_go = 1'b1;
    step(); fetch_go = 1'b0;
    imem_ack = 1'b1; imem_rdata = word;
    step(); imem_ack = 1'b0; imem_rdata = ~word;
    pulses = 0;
    pc = 32'h0000_0080; fetch_go = 1'b1;
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (instr_valid !== 1'b1 || instr !== word || instr_pc !== 32'h20 || imem_req !== 1'b0 || imem_addr !== 32'h20) begin
        failures++;
        $display("[TB] FAIL bp_hold_c%0d got=%b %h %h %b exp=1 %h 00000020 0", c, instr_valid, instr, instr_pc, imem_req, word);
      end
      if (pc_en) pulses++;
      step();
    end
    fetch_go = 1'b0;
    instr_ready = 1'b1;
    step(); instr_ready = 1'b0;
    checks++;
    if (pc_en !== 1'b1) begin
      failures++;
      $display("[TB] FAIL bp_pc_en got=%b exp=1", pc_en);
    end
    for (int c = 0; c < 3; c++) begin
      if (pc_en) pulses++;
      step();
    end
    checks++;
    if (pulses !== 1) begin
      failures++;
      $display("[TB] FAIL bp_pulse_count got=%0d exp=1", pulses);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    pc = 32'h0000_0100; fetch_go = 1'b1;
    step(); fetch_go = 1'b0;
    imem_ack = 1'b1; imem_rdata = 32'h1111_2222;
    step(); imem_ack = 1'b0;
    instr_ready = 1'b1;
    step(); instr_ready = 1'b0;
    pc = 32'h0000_0104; fetch_go = 1'b1;
    step(); fetch_go = 1'b0;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h104 || instr_pc !== 32'h104) begin
      failures++;
      $display("[TB] FAIL b2b_req got=%b %h %h exp=1 00000104 00000104", imem_req, imem_addr, instr_pc);
    end
    imem_ack = 1'b1; imem_rdata = 32'h3333_4444;
    step(); imem_ack = 1'b0;
    checks++;
    if (instr_valid !== 1'b1 || instr !== 32'h3333_4444) begin
      failures++;
      $display("[TB] FAIL b2b_instr got=%b %h exp=1 33334444", instr_valid, instr);
    end
  endtask

  task automatic test_flush_req();
    do_reset();
    pc = 32'h0000_0200; fetch_go = 1'b1;
    step(); fetch_go = 1'b0;
    flush = 1'b1;
    step(); flush = 1'b0;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin
      failures++;
      $display("[TB] FAIL flreq_req_kept got=%b %h exp=1 00000200", imem_req, imem_addr);
    end
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    step(); imem_ack = 1'b0; instr_ready = 1'b1;
    checks++;
    if (instr_valid !== 1'b0 || imem_req !== 1'b0) begin
      failures++;
      $display("[TB] FAIL flreq_drop got=%b/%b exp=0/0", instr_valid, imem_req);
    end
    step();
    checks++;
    if (pc_en !== 1'b0 || instr_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL flreq_no_pc_en got=%b/%b exp=0/0", pc_en, instr_valid);
    end
    instr_ready = 1'b0;
    pc = 32'h0000_0204; fetch_go = 1'b1;
    step(); fetch_go = 1'b0;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h204) begin
      failures++;
      $display("[TB] FAIL flreq_idle_again got=%b %h exp=1 00000204", imem_req, imem_addr);
    end
  endtask

  task automatic test_flush_valid();
    do_reset();
    pc = 32'h0000_0300; fetch_go = 1'b1;
    step(); fetch_go = 1'b0;
    imem_ack = 1'b1; imem_rdata = 32'h5555_6666;
    step(); imem_ack = 1'b0;
    flush = 1'b1; instr_ready = 1'b1;
    step(); flush = 1'b0; instr_ready = 1'b0;
    checks++;
    if (instr_valid !== 1'b0 || pc_en !== 1'b0) begin
      failures++;
      $display("[TB] FAIL flvalid got=%b/%b exp=0/0", instr_valid, pc_en);
    end
    step();
    checks++;
    if (pc_en !== 1'b0) begin
      failures++;
      $display("[TB] FAIL flvalid_later got=%b exp=0", pc_en);
    end
  endtask

  task automatic test_misaligned();
    do_reset();
    pc = 32'h0000_0006; fetch_go = 1'b1;
    step(); fetch_go = 1'b0;
    checks++;
    if (fetch_err !== 1'b1 || imem_req !== 1'b0) begin
      failures++;
      $display("[TB] FAIL misal_err got=%b/%b exp=1/0", fetch_err, imem_req);
    end
    pc = 32'h0000_0040; fetch_go = 1'b1;
    step(); step(); fetch_go = 1'b0;
    checks++;
    if (fetch_err !== 1'b1 || imem_req !== 1'b0 || instr_valid !== 1'b0 || pc_en !== 1'b0) begin
      failures++;
      $display("[TB] FAIL misal_terminal got=%b%b%b%b exp=1000", fetch_err, imem_req, instr_valid, pc_en);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (fetch_err !== 1'b0 || imem_req !== 1'b0) begin
      failures++;
      $display("[TB] FAIL misal_reset got=%b/%b exp=0/0", fetch_err, imem_req);
    end
    step();
    reset = 1'b1;
    step();
  endtask

  task automatic test_reset_in_req();
    do_reset();
    pc = 32'h0000_0400; fetch_go = 1'b1;
    step(); fetch_go = 1'b0;
    #2 reset = 1'b0;
    #1;
    checks++;
    if (imem_req !== 1'b0 || imem_addr !== 32'h0) begin
      failures++;
      $display("[TB] FAIL rstreq_async got=%b %h exp=0 00000000", imem_req, imem_addr);
    end
    step();
    reset = 1'b1;
    imem_ack = 1'b1; imem_rdata = 32'h7777_8888;
    step(); imem_ack = 1'b0;
    checks++;
    if (instr_valid !== 1'b0 || imem_req !== 1'b0 || instr !== 32'h0) begin
      failures++;
      $display("[TB] FAIL rstreq_late_ack got=%b %b %h exp=0 0 00000000", instr_valid, imem_req, instr);
    end
  endtask

  task automatic test_timeout();
    int bad;
    do_reset();
    pc = 32'h0000_0500; fetch_go = 1'b1;
    step(); fetch_go = 1'b0;
    bad = 0;
`ifdef IFETCH_TIMEOUT_EN
    for (int c = 1; c <= 8; c++) begin
      if (imem_req !== 1'b1 || timeout !== 1'b0) bad++;
      if (c < 8) step();
    end
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("[TB] FAIL tmo_wait got=%0d bad cycles exp=0", bad);
    end
    step();
    checks++;
    if (timeout !== 1'b1 || imem_req !== 1'b0) begin
      failures++;
      $display("[TB] FAIL tmo_fire got=%b/%b exp=1/0", timeout, imem_req);
    end
    pc = 32'h0000_0600; fetch_go = 1'b1;
    step(); step(); fetch_go = 1'b0;
    checks++;
    if (timeout !== 1'b1 || imem_req !== 1'b0 || instr_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL tmo_err_state got=%b%b%b exp=100", timeout, imem_req, instr_valid);
    end
`else
    for (int c = 0; c < 100; c++) begin
      if (imem_req !== 1'b1 || timeout !== 1'b0 || imem_addr !== 32'h500) bad++;
      step();
    end
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("[TB] FAIL notmo_wait got=%0d bad cycles exp=0", bad);
    end
`endif
    do_reset();
    checks++;
    if (timeout !== 1'b0) begin
      failures++;
      $display("[TB] FAIL tmo_reset got=%b exp=0", timeout);
    end
  endtask

  task automatic test_random();
    logic [31:0] exp_q[$];
    logic [31:0] fpc;
    logic [31:0] word;
    int ack_dly, rdy_dly, fl_at;
    bit  fl_req, fl_valid, delivered, exp_pulse;
    do_reset();
    for (int t = 0; t < 30; t++) begin
      fpc = $urandom & 32'hFFFF_FFFC;
      word = $urandom;
      ack_dly = $urandom_range(0, 4);
      rdy_dly = $urandom_range(0, 3);
      fl_req = (ack_dly > 0) && ($urandom_range(0, 3) == 0);
      fl_at = (ack_dly > 0) ? $urandom_range(0, ack_dly - 1) : 0;
      fl_valid = ($urandom_range(0, 4) == 0);
      delivered = !fl_req;
      exp_pulse = delivered && !fl_valid;
      if (delivered) exp_q.push_back(word);
      pc = fpc; fetch_go = 1'b1;
      step(); fetch_go = 1'b0; pc = $urandom;
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== fpc) begin
        failures++;
        $display("[TB] FAIL rnd%0d_req got=%b %h exp=1 %h", t, imem_req, imem_addr, fpc);
      end
      for (int d = 0; d < ack_dly; d++) begin
        flush = fl_req && (d == fl_at);
        step();
        flush = 1'b0;
      end
      imem_ack = 1'b1; imem_rdata = word;
      step(); imem_ack = 1'b0; imem_rdata = $urandom;
      if (!delivered) begin
        checks++;
        if (instr_valid !== 1'b0 || imem_req !== 1'b0) begin
          failures++;
          $display("[TB] FAIL rnd%0d_drop got=%b/%b exp=0/0", t, instr_valid, imem_req);
        end
        step();
        checks++;
        if (pc_en !== 1'b0) begin
          failures++;
          $display("[TB] FAIL rnd%0d_drop_pc_en got=%b exp=0", t, pc_en);
        end
      end else begin
        for (int d = 0; d <= rdy_dly; d++) begin
          checks++;
          if (instr_valid !== 1'b1 || instr !== exp_q[0] || instr_pc !== fpc || imem_req !== 1'b0) begin
            failures++;
            $display("[TB] FAIL rnd%0d_hold got=%b %h %h exp=1 %h %h", t, instr_valid, instr, instr_pc, exp_q[0], fpc);
          end
          if (d < rdy_dly) step();
        end
        void'(exp_q.pop_front());
        instr_ready = 1'b1; flush = fl_valid;
        step(); instr_ready = 1'b0; flush = 1'b0;
        checks++;
        if (instr_valid !== 1'b0 || pc_en !== exp_pulse) begin
          failures++;
          $display("[TB] FAIL rnd%0d_done got=%b/%b exp=0/%b", t, instr_valid, pc_en, exp_pulse);
        end
        step();
        checks++;
        if (pc_en !== 1'b0) begin
          failures++;
          $display("[TB] FAIL rnd%0d_pulse_once got=%b exp=0", t, pc_en);
        end
      end
    end
  endtask

  // Scenario sequence followed by the single summary line.
  initial begin
    test_reset();
    test_basic_fetch();
    test_backpressure();
    test_back_to_back();
    test_flush_req();
    test_flush_valid();
    test_random();
    test_reset_in_req();
    test_misaligned();
    test_timeout();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ifetch_stage.md
IFETCH_STAGE -- requirements
Module: ifetch_stage

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255: REQ-state cycles without imem_ack before timeout; only used when IFETCH_TIMEOUT_EN is defined.
REQ-002 clock  in  1  single clock; all state updates on the rising edge.
REQ-003 reset  in  1  reset is asynchronous and active-low.
REQ-004 pc  in  32  current PC value from the PC stage.
REQ-005 fetch_go  in  1  request a fetch at pc; sampled only in IDLE.
REQ-006 flush  in  1  discard the in-flight or held instruction, for example on a taken branch.
REQ-007 imem_req  out  1  instruction memory read request.
REQ-008 imem_addr  out  32  read address; held stable while imem_req is high.
REQ-009 imem_ack  in  1  memory accept; imem_rdata is valid in the same cycle.
REQ-010 imem_rdata  in  32  instruction word.
REQ-011 instr  out  32  fetched instruction.
REQ-012 instr_valid  out  1  instr and instr_pc are valid.
REQ-013 instr_ready  in  1  downstream decode accepts instr.
REQ-014 instr_pc  out  32  address instr was fetched from.
REQ-015 pc_en  out  1  one-cycle pulse driving the PC stage en input.
REQ-016 fetch_err  out  1  sticky misaligned-fetch flag.
REQ-017 timeout  out  1  sticky fetch-timeout flag.

Function
REQ-018 The FSM SHALL have exactly four states: IDLE, REQ, VALID and ERR; all outputs SHALL be registered.
REQ-019 In IDLE, fetch_go=1 with pc[1:0]=00 SHALL move the FSM to REQ and latch pc into imem_addr and instr_pc.
- In that case, imem_req SHALL be 1 in the next cycle.
REQ-020 In IDLE, fetch_go=1 with pc[1:0]!=00 SHALL move the FSM to ERR and set fetch_err.
- No memory request SHALL be issued.
REQ-021 In REQ, imem_req SHALL stay 1 and imem_addr SHALL stay stable until imem_ack is sampled 1.
REQ-022 imem_ack=1 in cycle M SHALL capture imem_rdata into instr, set instr_valid=1 in M+1, deassert imem_req in M+1 and move the FSM to VALID.
REQ-023 A flush during REQ SHALL set a drop flag without withdrawing the request.
- On the following ack, the data SHALL be discarded, the FSM SHALL return to IDLE, and instr_valid SHALL stay 0.
REQ-024 In VALID, instr, instr_pc and instr_valid SHALL hold until instr_valid and instr_ready are both 1 (handshake cycle K).
- Then pc_en SHALL be 1 for exactly cycle K+1, instr_valid SHALL be 0 in K+1, and the FSM SHALL move to IDLE.
REQ-025 In VALID, flush SHALL clear instr_valid next cycle and return the FSM to IDLE with no pc_en pulse.
- Flush SHALL win over a simultaneous instr_ready.
REQ-026 fetch_go SHALL be ignored in REQ, VALID and ERR.
- fetch_go in IDLE during the pc_en cycle SHALL be honoured.
REQ-027 ERR SHALL be terminal until reset: imem_req=0, instr_valid=0, pc_en=0.
REQ-028 imem_req SHALL never be 1 in IDLE, VALID or ERR.
REQ-029 pc_en SHALL never be 1 outside the cycle after a handshake.

Reset
REQ-030 While reset=0, all of the following SHALL be 0 asynchronously: FSM=IDLE, imem_req, imem_addr, instr, instr_valid, instr_pc, pc_en, fetch_err, timeout, drop flag and timeout counter.
REQ-031 Reset asserted mid-REQ SHALL drop imem_req immediately.
- After release, the block SHALL wait in IDLE for fetch_go; a late imem_ack SHALL be ignored.

Configuration
REQ-032 With macro IFETCH_TIMEOUT_EN defined, a counter SHALL count REQ cycles without ack.
- When the count reaches TIMEOUT_CYCLES, timeout SHALL be set (sticky), imem_req SHALL deassert and the FSM SHALL move to ERR.
- The counter SHALL clear on entering REQ.
REQ-033 Without IFETCH_TIMEOUT_EN, the REQ state SHALL wait indefinitely, timeout SHALL be tied 0, the port SHALL remain present and no counter logic SHALL be synthesised.

Verification
REQ-034 Basic fetch:
- Stimulus: pc=0x0000_0010, fetch_go pulse at cycle 0; ack at cycle 3 with rdata=0x0123_4567; instr_ready=1.
- Required response: imem_req=1 in cycles 1-3; instr_valid=1 in cycle 4 with instr=0x0123_4567 and instr_pc=0x10; pc_en=1 in cycle 5 only.
REQ-035 Backpressure:
- Stimulus: instr_ready=0 for 5 cycles after valid, then 1.
- Required response: instr is held stable; exactly one pc_en pulse, one cycle after ready.
REQ-036 Flush:
- Stimulus: flush in REQ, then ack with rdata=0xDEAD_BEEF.
- Required response: instr_valid stays 0; no pc_en.
- Stimulus: flush together with instr_ready in VALID.
- Required response: no pc_en.
REQ-037 Misaligned and reset:
- Stimulus: pc=0x0000_0006 with fetch_go.
- Required response: fetch_err=1, imem_req=0; reset=0 clears both.
- Stimulus: reset during REQ.
- Required response: imem_req=0 with no clock edge.
REQ-038 Timeout (IFETCH_TIMEOUT_EN, TIMEOUT_CYCLES=8):
- Stimulus: no ack.
- Required response: timeout=1 after 8 REQ cycles, imem_req=0, FSM in ERR.
- Without the macro, the same stimulus SHALL keep imem_req=1 and timeout=0 for 100 cycles.
